// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
//   Shared types and constants for the decode-stage immediate generator.
//   - imm_fmt_e : immediate format classification carried with each beat
//   - OPC_*     : RV32/RV64 base opcodes recognised by the decoder
// ---------------------------------------------------------------------------
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // funct3 values of OP-IMM that carry a shift amount instead of an immediate
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

endpackage

// File: rtl/imm_decode_comb.sv
// ---------------------------------------------------------------------------
// imm_decode_comb
//   Pure combinational immediate extraction for one instruction word.
//   Ports:
//     inst     in  32    raw instruction word
//     imm      out XLEN  sign-extended immediate (zero-extended for shifts)
//     fmt      out 3     imm_fmt_e classification
//     illegal  out 1     opcode outside the supported set
// ---------------------------------------------------------------------------
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  logic [5:0]  shamt;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // RV64 shifts use a 6-bit shamt; RV32 only has 5 bits, so bit 25 is ignored
  assign shamt = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};

  // Build every signed immediate as a 32-bit value first, then widen it by
  // sign extension from bit 31. Shift amounts are the only zero-extended case.
  always_comb begin
    imm32   = 32'd0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    imm     = '0;
    unique case (opcode)
      OPC_LOAD, OPC_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_OPIMM: begin
        if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
          fmt = FMT_SH;
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{inst[31]}}, inst[31:20]};
        end
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_OP, OPC_SYSTEM, OPC_MISCMEM: begin
        fmt = FMT_NONE;
      end
      default: begin
        fmt     = FMT_NONE;
        illegal = 1'b1;
      end
    endcase

    if (fmt == FMT_SH) begin
      imm = XLEN'(shamt);
    end else begin
      imm = XLEN'($signed(imm32));
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//   Registered immediate generator for the decode stage, behind a valid/ready
//   skid buffer (main output register + one skid register, strict FIFO).
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     flush                drop both held entries and this cycle's input beat
//     in_valid/in_ready    input handshake (in_ready is a register)
//     in_inst              raw instruction word
//     out_valid/out_ready  output handshake
//     out_inst             instruction aligned with out_imm
//     out_imm              extended immediate (XLEN bits)
//     out_fmt              imm_fmt_e classification
//     out_illegal          unsupported opcode flag
// ---------------------------------------------------------------------------
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_e        out_fmt,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // Decoded view of the incoming word; only captured when a beat is accepted
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  imm_decode_comb #(.XLEN(XLEN)) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Main (output) entry
  logic            main_valid;
  logic [31:0]     main_inst;
  logic [XLEN-1:0] main_imm;
  imm_fmt_e        main_fmt;
  logic            main_illegal;

  // Skid entry, holds the beat accepted while main was stalled
  logic            skid_valid;
  logic [31:0]     skid_inst;
  logic [XLEN-1:0] skid_imm;
  imm_fmt_e        skid_fmt;
  logic            skid_illegal;

  logic ready_q;
  logic accept;
  logic drain;
  logic main_valid_nxt;
  logic skid_valid_nxt;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign accept = in_valid & ready_q & ~flush;
  assign drain  = main_valid & out_ready;

  // Handshake control: decides where the accepted beat goes and how the two
  // entries advance. flush wins over everything; when the skid entry is full
  // in_ready is already low, so accept and skid refill never coincide.
  always_comb begin
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        load_main_skid = 1'b1;
        skid_valid_nxt = 1'b0;
      end else if (accept) begin
        load_main_in = 1'b1;
      end else begin
        main_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      if (main_valid) begin
        load_skid      = 1'b1;
        skid_valid_nxt = 1'b1;
      end else begin
        load_main_in   = 1'b1;
        main_valid_nxt = 1'b1;
      end
    end
  end

  // Valid bits and the registered in_ready. in_ready mirrors the next skid
  // state so it never depends combinationally on out_ready, and is held low
  // for as long as reset is asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      ready_q    <= ~skid_valid_nxt;
    end
  end

  // Main entry payload: refilled either from the decoder or from the skid
  // entry; otherwise it holds, which keeps outputs stable under back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_inst    <= 32'd0;
      main_imm     <= '0;
      main_fmt     <= FMT_NONE;
      main_illegal <= 1'b0;
    end else if (load_main_skid) begin
      main_inst    <= skid_inst;
      main_imm     <= skid_imm;
      main_fmt     <= skid_fmt;
      main_illegal <= skid_illegal;
    end else if (load_main_in) begin
      main_inst    <= in_inst;
      main_imm     <= dec_imm;
      main_fmt     <= dec_fmt;
      main_illegal <= dec_illegal;
    end
  end

  // Skid entry payload: only written when a beat arrives while main stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_inst    <= 32'd0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_illegal <= 1'b0;
    end else if (load_skid) begin
      skid_inst    <= in_inst;
      skid_imm     <= dec_imm;
      skid_fmt     <= dec_fmt;
      skid_illegal <= dec_illegal;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = main_valid;
  assign out_inst    = main_inst;
  assign out_imm     = main_imm;
  assign out_fmt     = main_fmt;
  assign out_illegal = main_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Directed bench for imm_gen_pipe. A 32-bit and a 64-bit instance share the
//   same stimulus; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_inst32, out_imm32;
  imm_fmt_e    out_fmt32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_inst64;
  logic [63:0] out_imm64;
  imm_fmt_e    out_fmt64;

  int testsRun = 0;
  int testsFailed = 0;

  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
  localparam logic [31:0] I_SRAI = 32'h4030D093;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_LUIN = 32'h800000B7;
  localparam logic [31:0] I_SW   = 32'h00112623;
  localparam logic [31:0] I_JAL  = 32'hFF9FF06F;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
    .out_valid(out_valid32), .out_ready(out_ready), .out_inst(out_inst32),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst),
    .out_valid(out_valid64), .out_ready(out_ready), .out_inst(out_inst64),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  task automatic applyStimulus(input logic v, input logic [31:0] inst,
                               input logic rdy, input logic fl);
    in_valid  = v;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Advance one clock and settle just past the rising edge
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat32(input string tag, input logic [31:0] inst,
                             input logic [31:0] imm, input imm_fmt_e fmt,
                             input logic ill);
    checkOutput({tag, "_valid"}, 64'(out_valid32), 64'd1);
    checkOutput({tag, "_inst"}, 64'(out_inst32), 64'(inst));
    checkOutput({tag, "_imm"}, 64'(out_imm32), 64'(imm));
    checkOutput({tag, "_fmt"}, 64'(out_fmt32), 64'(fmt));
    checkOutput({tag, "_ill"}, 64'(out_illegal32), 64'(ill));
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("rst_out_valid", 64'(out_valid32), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready32), 64'd0);
    checkOutput("rst_out_imm", 64'(out_imm32), 64'd0);
    checkOutput("rst_out_fmt", 64'(out_fmt32), 64'(FMT_NONE));
    reset = 1'b0;
    stepCycle();
    checkOutput("post_rst_in_ready", 64'(in_ready32), 64'd1);
    checkOutput("post_rst_in_ready64", 64'(in_ready64), 64'd1);

    // Streaming decode, out_ready held high: one result per cycle, no bubbles
    applyStimulus(1'b1, I_ADDI, 1'b1, 1'b0);
    stepCycle();
    checkBeat32("addi", I_ADDI, 32'hFFFFFFFF, FMT_I, 1'b0);
    checkOutput("addi_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFF);

    applyStimulus(1'b1, I_BEQ, 1'b1, 1'b0);
    stepCycle();
    checkBeat32("beq", I_BEQ, 32'hFFFFFFFC, FMT_B, 1'b0);

    applyStimulus(1'b1, I_SRAI, 1'b1, 1'b0);
    stepCycle();
    checkBeat32("srai", I_SRAI, 32'd3, FMT_SH, 1'b0);
    checkOutput("srai_imm64", out_imm64, 64'd3);

    applyStimulus(1'b1, I_LUI, 1'b1, 1'b0);
    stepCycle();
    checkBeat32("lui", I_LUI, 32'h12345000, FMT_U, 1'b0);
    checkOutput("lui_imm64", out_imm64, 64'h0000000012345000);

    applyStimulus(1'b1, I_LUIN, 1'b1, 1'b0);
    stepCycle();
    checkOutput("luin_imm32", 64'(out_imm32), 64'h80000000);
    checkOutput("luin_imm64", out_imm64, 64'hFFFFFFFF80000000);
    checkOutput("luin_fmt64", 64'(out_fmt64), 64'(FMT_U));

    applyStimulus(1'b1, I_SW, 1'b1, 1'b0);
    stepCycle();
    checkBeat32("sw", I_SW, 32'd12, FMT_S, 1'b0);

    applyStimulus(1'b1, I_JAL, 1'b1, 1'b0);
    stepCycle();
    checkBeat32("jal", I_JAL, 32'hFFFFFFF8, FMT_J, 1'b0);
    checkOutput("jal_imm64", out_imm64, 64'hFFFFFFFFFFFFFFF8);

    applyStimulus(1'b1, I_ADD, 1'b1, 1'b0);
    stepCycle();
    checkBeat32("add", I_ADD, 32'd0, FMT_NONE, 1'b0);

    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("idle_out_valid", 64'(out_valid32), 64'd0);

    // Back-pressure: three back-to-back beats with out_ready low
    applyStimulus(1'b1, I_ADDI, 1'b0, 1'b0);
    stepCycle();
    checkOutput("bp1_in_ready", 64'(in_ready32), 64'd1);
    applyStimulus(1'b1, I_BEQ, 1'b0, 1'b0);
    stepCycle();
    checkOutput("bp2_in_ready", 64'(in_ready32), 64'd0);
    checkBeat32("bp2_hold", I_ADDI, 32'hFFFFFFFF, FMT_I, 1'b0);
    applyStimulus(1'b1, I_LUI, 1'b0, 1'b0);
    stepCycle();
    checkOutput("bp3_in_ready", 64'(in_ready32), 64'd0);
    checkBeat32("bp3_hold", I_ADDI, 32'hFFFFFFFF, FMT_I, 1'b0);
    applyStimulus(1'b1, I_LUI, 1'b1, 1'b0);
    stepCycle();
    checkBeat32("bp_out2", I_BEQ, 32'hFFFFFFFC, FMT_B, 1'b0);
    checkOutput("bp_ready_back", 64'(in_ready32), 64'd1);
    stepCycle();
    checkBeat32("bp_out3", I_LUI, 32'h12345000, FMT_U, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("bp_drained", 64'(out_valid32), 64'd0);

    // Flush with both entries full and a live input beat
    applyStimulus(1'b1, I_SW, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, I_JAL, 1'b0, 1'b0);
    stepCycle();
    checkOutput("fl_full_in_ready", 64'(in_ready32), 64'd0);
    applyStimulus(1'b1, I_SRAI, 1'b0, 1'b1);
    stepCycle();
    checkOutput("fl_out_valid", 64'(out_valid32), 64'd0);
    checkOutput("fl_in_ready", 64'(in_ready32), 64'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("fl_gone1", 64'(out_valid32), 64'd0);
    stepCycle();
    checkOutput("fl_gone2", 64'(out_valid32), 64'd0);

    // Illegal opcode, then reset while stalled with both entries full
    applyStimulus(1'b1, I_BAD, 1'b0, 1'b0);
    stepCycle();
    checkBeat32("illegal", I_BAD, 32'd0, FMT_NONE, 1'b1);
    applyStimulus(1'b1, I_SW, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    stepCycle();
    checkOutput("mrst_valid", 64'(out_valid32), 64'd0);
    checkOutput("mrst_inst", 64'(out_inst32), 64'd0);
    checkOutput("mrst_imm", 64'(out_imm32), 64'd0);
    checkOutput("mrst_fmt", 64'(out_fmt32), 64'(FMT_NONE));
    checkOutput("mrst_ill", 64'(out_illegal32), 64'd0);
    checkOutput("mrst_in_ready", 64'(in_ready32), 64'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("mrst_after_ready", 64'(in_ready32), 64'd1);
    checkOutput("mrst_after_valid", 64'(out_valid32), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
